// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: request side (in_*), flush, and result side (out_*).
interface ext_pipe_if #(
  parameter int unsigned OUT_W = 32
);
  localparam int unsigned LANE_W = $clog2(OUT_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  in_data;
  logic [2:0]        in_mode;
  logic [LANE_W-1:0] in_lane;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_misalign;

  // Producer/consumer side of the pipe.
  modport master (
    output in_valid, in_data, in_mode, in_lane, flush, out_ready,
    input  in_ready, out_valid, out_data, out_misalign
  );

  // The extender itself.
  modport slave (
    input  in_valid, in_data, in_mode, in_lane, flush, out_ready,
    output in_ready, out_valid, out_data, out_misalign
  );
endinterface

// File: rtl/ext_pipe.sv
// Pipelined immediate / load-data extender. The extension is computed combinationally
// on the request and captured into slot 0; STAGES valid/ready slots follow.
module ext_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned STAGES = 1
) (
  input logic       clk,
  input logic       reset,
  ext_pipe_if.slave bus
);
  localparam int unsigned LANE_W = $clog2(OUT_W / 8);

  typedef enum logic [2:0] {
    ModeSign  = 3'd0,
    ModeZero  = 3'd1,
    ModeLui   = 3'd2,
    ModeByteS = 3'd3,
    ModeByteU = 3'd4,
    ModeHalfS = 3'd5,
    ModeHalfU = 3'd6,
    ModeRsvd  = 3'd7
  } mode_e;

  logic [IN_W-1:0]   imm;
  logic [LANE_W-1:0] half_lane;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [OUT_W-1:0]  ext_data;
  logic              ext_mis;

  logic [STAGES:0]   ready;
  logic              in_ready;
  logic              in_fire;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] mis_q, mis_d;
  logic [OUT_W-1:0]  data_q [STAGES];
  logic [OUT_W-1:0]  data_d [STAGES];

  // Extension function on the incoming request.
  always_comb begin
    imm       = bus.in_data[IN_W-1:0];
    // Halfwords are taken from the even lane; an odd lane only raises the flag.
    half_lane = bus.in_lane & ~LANE_W'(1);
    byte_val  = 8'(bus.in_data >> {bus.in_lane, 3'b000});
    half_val  = 16'(bus.in_data >> {half_lane, 3'b000});
    ext_data  = '0;
    ext_mis   = 1'b0;
    unique case (mode_e'(bus.in_mode))
      ModeSign:  ext_data = OUT_W'($signed(imm));
      ModeZero:  ext_data = OUT_W'(imm);
      ModeLui:   ext_data = OUT_W'(imm) << (OUT_W - IN_W);
      ModeByteS: ext_data = OUT_W'($signed(byte_val));
      ModeByteU: ext_data = OUT_W'(byte_val);
      ModeHalfS: begin
        ext_data = OUT_W'($signed(half_val));
        ext_mis  = bus.in_lane[0];
      end
      ModeHalfU: begin
        ext_data = OUT_W'(half_val);
        ext_mis  = bus.in_lane[0];
      end
      ModeRsvd: begin
        ext_data = '0;
        ext_mis  = 1'b1;
      end
      default: begin
        ext_data = '0;
        ext_mis  = 1'b0;
      end
    endcase
  end

  // Slot k can accept when it or any slot downstream of it has a free place, or the
  // consumer takes the head. Written flat to keep the chain free of self-loops.
  always_comb begin
    logic r;
    for (int k = 0; k <= STAGES; k++) begin
      r = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        r = r | ~valid_q[j];
      end
      ready[k] = r;
    end
    in_ready = ready[0] & ~bus.flush;
    in_fire  = bus.in_valid & in_ready;
  end

  // Slot advance; flush only clears valids, payload registers keep their contents.
  always_comb begin
    logic             up_valid;
    logic [OUT_W-1:0] up_data;
    logic             up_mis;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      mis_d[k]   = mis_q[k];
      if (k == 0) begin
        up_valid = in_fire;
        up_data  = ext_data;
        up_mis   = ext_mis;
      end else begin
        up_valid = valid_q[k-1];
        up_data  = data_q[k-1];
        up_mis   = mis_q[k-1];
      end
      if (bus.flush) begin
        valid_d[k] = 1'b0;
      end else if (ready[k]) begin
        valid_d[k] = up_valid;
        if (up_valid) begin
          data_d[k] = up_data;
          mis_d[k]  = up_mis;
        end
      end
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      mis_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      mis_q   <= mis_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Interface outputs come straight from the last slot.
  always_comb begin
    bus.in_ready     = in_ready;
    bus.out_valid    = valid_q[STAGES-1];
    bus.out_data     = data_q[STAGES-1];
    bus.out_misalign = mis_q[STAGES-1];
  end
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: four instances cover STAGES=1/2/3 and a 64-bit build.
module tb_ext_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ext_pipe_if #(.OUT_W(32)) if1 ();
  ext_pipe_if #(.OUT_W(32)) if2 ();
  ext_pipe_if #(.OUT_W(32)) if3 ();
  ext_pipe_if #(.OUT_W(64)) if64 ();

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
  ext_pipe #(.IN_W(8), .OUT_W(64), .STAGES(4)) u64 (.clk(clk), .reset(reset), .bus(if64.slave));

  // Behavioural reference: extension rules in plain arithmetic.
  function automatic void ref_ext(input logic [63:0] d, input int mode, input int lane,
                                  input int in_w, input int out_w,
                                  output logic [63:0] r, output logic m);
    logic [63:0] omask, imask, v;
    omask = (out_w == 64) ? '1 : ((64'd1 << out_w) - 64'd1);
    imask = (in_w == 64) ? '1 : ((64'd1 << in_w) - 64'd1);
    r = '0;
    m = 1'b0;
    case (mode)
      0: begin
        v = d & imask;
        if (((v >> (in_w - 1)) & 64'd1) == 64'd1) v = v | ~imask;
        r = v & omask;
      end
      1: r = d & imask;
      2: r = ((d & imask) << (out_w - in_w)) & omask;
      3, 4: begin
        v = (d >> (8 * lane)) & 64'hFF;
        if (mode == 3 && v >= 64'd128) v = v - 64'd256;
        r = v & omask;
      end
      5, 6: begin
        v = (d >> (8 * (lane - lane % 2))) & 64'hFFFF;
        if (mode == 5 && v >= 64'd32768) v = v - 64'd65536;
        r = v & omask;
        m = (lane % 2) == 1;
      end
      default: begin
        r = '0;
        m = 1'b1;
      end
    endcase
  endfunction

  task automatic idle_all();
    if1.in_valid = 0; if1.in_data = '0; if1.in_mode = '0; if1.in_lane = '0;
    if1.flush = 0; if1.out_ready = 1;
    if2.in_valid = 0; if2.in_data = '0; if2.in_mode = '0; if2.in_lane = '0;
    if2.flush = 0; if2.out_ready = 1;
    if3.in_valid = 0; if3.in_data = '0; if3.in_mode = '0; if3.in_lane = '0;
    if3.flush = 0; if3.out_ready = 1;
    if64.in_valid = 0; if64.in_data = '0; if64.in_mode = '0; if64.in_lane = '0;
    if64.flush = 0; if64.out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (if1.out_valid !== 1'b0 || if2.out_valid !== 1'b0 || if3.out_valid !== 1'b0 ||
        if64.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b%b%b%b want 0000", if1.out_valid,
               if2.out_valid, if3.out_valid, if64.out_valid);
    end
    checks++;
    if (if1.out_data !== 32'd0 || if3.out_data !== 32'd0 || if64.out_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_out_data: got %h %h %h want 0", if1.out_data, if3.out_data,
               if64.out_data);
    end
    checks++;
    if (if1.out_misalign !== 1'b0 || if3.out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign: got %b %b want 0", if1.out_misalign, if3.out_misalign);
    end
    checks++;
    if (if1.in_ready !== 1'b1 || if2.in_ready !== 1'b1 || if3.in_ready !== 1'b1 ||
        if64.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b%b%b want 1111", if1.in_ready, if2.in_ready,
               if3.in_ready, if64.in_ready);
    end
  endtask

  // One request into the STAGES=1 instance; result must appear exactly one edge later.
  task automatic send_one(input string name, input logic [31:0] d, input logic [2:0] mode,
                          input logic [1:0] lane, input logic [31:0] exp_d,
                          input logic exp_m);
    if1.in_valid = 1; if1.in_data = d; if1.in_mode = mode; if1.in_lane = lane;
    #1;
    checks++;
    if (if1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid=%b want 0", name, if1.out_valid);
    end
    tick();
    if1.in_valid = 0;
    checks++;
    if (if1.out_valid !== 1'b1 || if1.out_data !== exp_d || if1.out_misalign !== exp_m) begin
      errors++;
      $display("FAIL %s: valid=%b data=%h mis=%b want 1 %h %b", name, if1.out_valid,
               if1.out_data, if1.out_misalign, exp_d, exp_m);
    end
    tick();
    checks++;
    if (if1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_once: out_valid=%b want 0", name, if1.out_valid);
    end
  endtask

  task automatic test_imm();
    send_one("sign", 32'h0000_8001, 3'd0, 2'd0, 32'hFFFF_8001, 1'b0);
    send_one("zero", 32'h0000_8001, 3'd1, 2'd0, 32'h0000_8001, 1'b0);
    send_one("lui",  32'h0000_8001, 3'd2, 2'd0, 32'h8001_0000, 1'b0);
  endtask

  task automatic test_lanes();
    send_one("byte_s_l3", 32'h80F1_7F02, 3'd3, 2'd3, 32'hFFFF_FF80, 1'b0);
    send_one("byte_u_l2", 32'h80F1_7F02, 3'd4, 2'd2, 32'h0000_00F1, 1'b0);
    send_one("half_s_l2", 32'h80F1_7F02, 3'd5, 2'd2, 32'hFFFF_80F1, 1'b0);
    send_one("half_u_l0", 32'h80F1_7F02, 3'd6, 2'd0, 32'h0000_7F02, 1'b0);
    send_one("half_u_l1", 32'h80F1_7F02, 3'd6, 2'd1, 32'h0000_7F02, 1'b1);
    send_one("rsvd",      32'h80F1_7F02, 3'd7, 2'd0, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int drop_at = -1;
    logic [31:0] got[$];
    bit held_ok = 1;
    if3.out_ready = 0; if3.in_mode = 3'd0; if3.in_valid = 1; if3.in_data = 32'd1;
    for (int cyc = 0; cyc < 30 && got.size() < 5; cyc++) begin
      if (cyc == 8) if3.out_ready = 1;
      #1;
      if (cyc >= 4 && cyc < 8) begin
        if (if3.out_valid !== 1'b1 || if3.out_data !== 32'd1) held_ok = 0;
      end
      if (!if3.in_ready && drop_at < 0 && if3.in_valid) drop_at = sent;
      if (if3.out_valid && if3.out_ready) got.push_back(if3.out_data);
      if (if3.in_valid && if3.in_ready) sent++;
      tick();
      if (sent < 5) if3.in_data = 32'(sent + 1);
      else if3.in_valid = 0;
    end
    if3.in_valid = 0; if3.out_ready = 1;
    checks++;
    if (drop_at !== 3) begin
      errors++;
      $display("FAIL bp_ready_drop: accepts before stall=%0d want 3", drop_at);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL bp_hold: head not held at valid=1 data=1 under stall");
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 5", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], i + 1);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    bit leaked = 0;
    if2.out_ready = 0; if2.in_mode = 3'd1; if2.in_valid = 1; if2.in_data = 32'h11;
    tick();
    if2.in_data = 32'h22;
    tick();
    checks++;
    if (if2.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: out_valid=%b want 1", if2.out_valid);
    end
    if2.flush = 1; if2.in_data = 32'h77;
    #1;
    checks++;
    if (if2.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b want 0", if2.in_ready);
    end
    tick();
    if2.flush = 0; if2.in_valid = 0;
    checks++;
    if (if2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: out_valid=%b want 0", if2.out_valid);
    end
    if2.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if2.out_valid !== 1'b0) leaked = 1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL flush_leak: a flushed or refused request reached the output");
    end
    checks++;
    if (if2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_recover: in_ready=%b want 1", if2.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    if3.out_ready = 0; if3.in_valid = 1; if3.in_data = 32'h1234_5678;
    if3.in_mode = 3'd5; if3.in_lane = 2'd1;
    tick();
    if3.in_valid = 0;
    tick();
    tick();
    checks++;
    if (if3.out_valid !== 1'b1 || if3.out_data !== 32'h0000_5678 || if3.out_misalign !== 1'b1)
    begin
      errors++;
      $display("FAIL rst_mid_pre: valid=%b data=%h mis=%b want 1 00005678 1", if3.out_valid,
               if3.out_data, if3.out_misalign);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if (if3.out_valid !== 1'b0 || if3.out_data !== 32'd0 || if3.out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: valid=%b data=%h mis=%b want 0 0 0", if3.out_valid,
               if3.out_data, if3.out_misalign);
    end
    @(negedge clk);
    reset = 0;
    tick();
    if3.out_ready = 1; if3.in_valid = 1; if3.in_data = 32'h0000_0005;
    if3.in_mode = 3'd0; if3.in_lane = 2'd0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if3.in_valid = 0;
      if (if3.out_valid) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 3 || if3.out_data !== 32'd5) begin
      errors++;
      $display("FAIL rst_mid_after: latency=%0d data=%h want 3 00000005", n, if3.out_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_d[$];
    logic        exp_m[$];
    logic [63:0] r;
    logic        m;
    logic [31:0] held_d;
    logic        held_m;
    bit          was_stalled = 0;
    int          outs = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 400) begin
        if3.in_valid  = ($urandom % 4) != 0;
        if3.in_data   = $urandom;
        if3.in_mode   = 3'($urandom_range(0, 7));
        if3.in_lane   = 2'($urandom_range(0, 3));
        if3.out_ready = ($urandom % 3) != 0;
      end else begin
        if3.in_valid  = 0;
        if3.out_ready = 1;
      end
      #1;
      if (was_stalled) begin
        checks++;
        if (if3.out_valid !== 1'b1 || if3.out_data !== held_d || if3.out_misalign !== held_m)
        begin
          errors++;
          $display("FAIL rnd_stable: valid=%b data=%h mis=%b want 1 %h %b", if3.out_valid,
                   if3.out_data, if3.out_misalign, held_d, held_m);
        end
      end
      if (if3.in_valid && if3.in_ready) begin
        ref_ext(64'(if3.in_data), int'(if3.in_mode), int'(if3.in_lane), 16, 32, r, m);
        exp_d.push_back(r[31:0]);
        exp_m.push_back(m);
      end
      if (if3.out_valid && if3.out_ready) begin
        checks++;
        outs++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: unexpected result %h", if3.out_data);
        end else begin
          if (if3.out_data !== exp_d[0] || if3.out_misalign !== exp_m[0]) begin
            errors++;
            $display("FAIL rnd_data: got %h/%b want %h/%b", if3.out_data, if3.out_misalign,
                     exp_d[0], exp_m[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_m.pop_front());
        end
      end
      was_stalled = if3.out_valid && !if3.out_ready;
      held_d = if3.out_data;
      held_m = if3.out_misalign;
      tick();
    end
    checks++;
    if (exp_d.size() != 0 || outs == 0) begin
      errors++;
      $display("FAIL rnd_drain: %0d results missing, %0d delivered", exp_d.size(), outs);
    end
  endtask

  task automatic sweep_one(input string name, input logic [63:0] d, input logic [2:0] mode,
                           input logic [2:0] lane, input logic [63:0] exp_d);
    int n = 0;
    if64.in_valid = 1; if64.in_data = d; if64.in_mode = mode; if64.in_lane = lane;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if64.in_valid = 0;
      if (if64.out_valid) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 4 || if64.out_data !== exp_d || if64.out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s: latency=%0d data=%h mis=%b want 4 %h 0", name, n, if64.out_data,
               if64.out_misalign, exp_d);
    end
    tick();
  endtask

  task automatic test_sweep();
    sweep_one("w64_sign", 64'h80, 3'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FF80);
    sweep_one("w64_lui", 64'h80, 3'd2, 3'd0, 64'h8000_0000_0000_0000);
    sweep_one("w64_byte_l7", 64'h7F00_0000_0000_0000, 3'd3, 3'd7, 64'h0000_0000_0000_007F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    #12;
    test_reset();
    @(negedge clk);
    reset = 0;
    tick();
    test_imm();
    test_lanes();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
